// File: rtl/vga_scanout_if.sv
// Frame-buffer read port between the VGA scanout (master) and the buffer (slave).
interface vga_scanout_if;
  logic       read_enable;
  logic [9:0] read_frame_width;
  logic [8:0] read_frame_height;
  logic [2:0] read_data;

  modport master (
    output read_enable,
    output read_frame_width,
    output read_frame_height,
    input  read_data
  );

  modport slave (
    input  read_enable,
    input  read_frame_width,
    input  read_frame_height,
    output read_data
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA raster generator and frame-buffer reader. Counters walk the raster on each
// pixel strobe. A clk-rate shift line delays the sync/blank/strobe information by
// the buffer read latency, so colour, syncs and blank leave the block on the same edge.
module vga_scanout #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int READ_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en_i,
  vga_scanout_if.master fb,
  output logic          vga_r_o,
  output logic          vga_g_o,
  output logic          vga_b_o,
  output logic          vga_hs_o,
  output logic          vga_vs_o,
  output logic          blank_o,
  output logic          frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int D       = READ_LATENCY + 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic pe;
    logic vis;
    logic hs;
    logic vs;
    logic org;
  } tap_t;

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       visible;
  tap_t       cur;
  tap_t       tail;
  tap_t [D-1:0] line_q;

  logic [2:0] rgb_q;
  logic       hs_q, vs_q, blank_q, fs_q;

  // Raster position next state: step on the strobe, wrap line then frame.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_i) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Raster position registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Visibility, raw syncs and read address decoded from the registered position.
  always_comb begin
    visible                = (h_q < H_VIS) && (v_q < V_VIS);
    cur.pe                 = pix_en_i;
    cur.vis                = visible;
    cur.hs                 = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    cur.vs                 = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    cur.org                = (h_q == '0) && (v_q == '0) && visible;
    fb.read_enable         = visible;
    fb.read_frame_width    = visible ? h_q : '0;
    fb.read_frame_height   = visible ? v_q[8:0] : '0;
    tail                   = line_q[D-1];
  end

  // Free-running delay line matching the buffer read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q[0] <= cur;
      for (int i = 1; i < D; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  // Output stage: load when the delayed strobe arrives; frame_start marks the origin pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= tail.pe && tail.org;
      if (tail.pe) begin
        rgb_q   <= tail.vis ? fb.read_data : 3'b000;
        hs_q    <= tail.hs;
        vs_q    <= tail.vs;
        blank_q <= !tail.vis;
      end
    end
  end

  assign vga_r_o       = rgb_q[2];
  assign vga_g_o       = rgb_q[1];
  assign vga_b_o       = rgb_q[0];
  assign vga_hs_o      = hs_q;
  assign vga_vs_o      = vs_q;
  assign blank_o       = blank_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout. Full horizontal timing, shortened vertical
// timing so several frames fit in a short run. A linear pixel-index model predicts
// addresses and the delayed display outputs.
module tb_vga_scanout;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  typedef struct {
    bit pe;
    int n;
  } pendEntry_t;

  logic clk = 1'b0;
  logic rst_n;
  logic pixEn;
  logic vgaR, vgaG, vgaB, vgaHs, vgaVs, blank, frameStart;

  int compareCount  = 0;
  int mismatchCount = 0;
  bit checking      = 1'b0;

  int         modelN = 0;
  logic [6:0] expOut = 7'b000_1_1_1_0;
  pendEntry_t pend[$];
  pendEntry_t popped;
  int         px, py;
  bit         pvis;

  logic [9:0] sampledX;
  logic [8:0] sampledY;
  logic       sampledEn;

  vga_scanout_if fbIf();

  vga_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .READ_LATENCY(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_en_i     (pixEn),
    .fb           (fbIf),
    .vga_r_o      (vgaR),
    .vga_g_o      (vgaG),
    .vga_b_o      (vgaB),
    .vga_hs_o     (vgaHs),
    .vga_vs_o     (vgaVs),
    .blank_o      (blank),
    .frame_start_o(frameStart)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] colourOf(input int x, input int y);
    return 3'((x + y) % 8);
  endfunction

  function automatic bit isVisible(input int n);
    return ((n % H_TOTAL) < H_ACTIVE) && ((n / H_TOTAL) < V_ACTIVE);
  endfunction

  function automatic logic [19:0] expAddr(input int n);
    if (isVisible(n)) return {1'b1, 10'(n % H_TOTAL), 9'(n / H_TOTAL)};
    return 20'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", tag, $time, observed, expected);
    end
  endtask

  // Frame buffer with one sampling edge plus one cycle of read latency.
  always @(posedge clk) begin
    sampledX         <= fbIf.read_frame_width;
    sampledY         <= fbIf.read_frame_height;
    sampledEn        <= fbIf.read_enable;
    fbIf.read_data   <= sampledEn ? colourOf(int'(sampledX), int'(sampledY)) : 3'b101;
  end

  // Reference: each strobe shows pixel index n three edges later; syncs from plain ranges.
  always @(posedge clk) begin
    if (!rst_n) begin
      pend.delete();
      modelN <= 0;
      expOut <= 7'b000_1_1_1_0;
    end else begin
      pend.push_back('{pe: pixEn, n: modelN});
      if (pixEn) modelN <= (modelN + 1) % FRAME;
      if (pend.size() == 3) begin
        popped = pend.pop_front();
        if (popped.pe) begin
          px   = popped.n % H_TOTAL;
          py   = popped.n / H_TOTAL;
          pvis = isVisible(popped.n);
          expOut <= {pvis ? colourOf(px, py) : 3'b000,
                     !(px >= H_ACTIVE + H_FP && px < H_ACTIVE + H_FP + H_SYNC),
                     !(py >= V_ACTIVE + V_FP && py < V_ACTIVE + V_FP + V_SYNC),
                     !pvis,
                     popped.n == 0};
        end else begin
          expOut <= {expOut[6:1], 1'b0};
        end
      end else begin
        expOut <= {expOut[6:1], 1'b0};
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("out", 32'({vgaR, vgaG, vgaB, vgaHs, vgaVs, blank, frameStart}), 32'(expOut));
      checkOutput("addr", 32'({fbIf.read_enable, fbIf.read_frame_width, fbIf.read_frame_height}),
                  32'(expAddr(modelN)));
    end
  end

  // Drive the strobe for a number of cycles: 0 = every cycle, 1 = one in four, 2 = random.
  task automatic applyStimulus(input int mode, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      case (mode)
        0:       pixEn = 1'b1;
        1:       pixEn = (i % 4) == 0;
        default: pixEn = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
    end
  endtask

  initial begin : mainSeq
    int guard;
    int waited;
    rst_n = 1'b0;
    pixEn = 1'b1;
    @(negedge clk);
    checking = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_out", 32'({vgaR, vgaG, vgaB, vgaHs, vgaVs, blank, frameStart}), 32'(7'b000_1_1_1_0));
    checkOutput("rst_addr", 32'({fbIf.read_enable, fbIf.read_frame_width, fbIf.read_frame_height}),
                32'({1'b1, 19'd0}));
    rst_n = 1'b1;

    $display("[TB] strobe every cycle across a frame wrap");
    applyStimulus(0, FRAME + 2000);
    $display("[TB] strobe one in four");
    applyStimulus(1, 4 * 900);
    $display("[TB] random strobe");
    applyStimulus(2, 6000);

    $display("[TB] reset mid-frame at (320,5)");
    pixEn = 1'b1;
    guard = 0;
    while (modelN != 5 * H_TOTAL + 320 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reach_320_5", 32'(modelN), 32'(5 * H_TOTAL + 320));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pixEn = 1'b0;
    checkOutput("mid_rst_out", 32'({vgaR, vgaG, vgaB, vgaHs, vgaVs, blank, frameStart}), 32'(7'b000_1_1_1_0));
    repeat ($urandom_range(1, 5)) @(negedge clk);
    pixEn = 1'b1;
    @(negedge clk);
    pixEn = 1'b0;
    waited = 1;
    while (frameStart !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("fs_latency", 32'(waited), 32'd3);

    $display("[TB] random strobe after reset");
    applyStimulus(2, 2 * FRAME);
    applyStimulus(0, 50);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
